cr_zigzag_rle: RTL and testbench
================================

Name: cr_zigzag_rle

Overview:
- Stage directly downstream of cr_quantizer in the Cr chroma path.
- Captures one quantized 8x8 block (the quantizer's Q matrix, qualified by its out_enable pulse) and scans it in JPEG zigzag order.
- Emits a serial stream of DC-differential and AC run/size/amplitude symbols (with ZRL/EOB) on a valid/ready interface for the Huffman stage.
- DC prediction is carried across blocks.

Parameters:
- COEF_W, 11, width of each quantized coefficient (signed).
- DIFF_W, 12, width of the DC difference (signed; range -2047..2047).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  block-valid pulse; connect to cr_quantizer out_enable.
- Q  in  COEF_W x [0:7][0:7]  quantized block, signed.
- in_ready  out  1  high when the block can accept a new matrix.
- sym_valid  out  1  symbol fields are valid.
- sym_ready  in  1  downstream accepts the symbol.
- sym_is_dc  out  1  current symbol is the DC symbol.
- sym_run  out  4  AC zero run, 0..15.
- sym_size  out  4  magnitude category, 0..11.
- sym_amp  out  11  JPEG amplitude bits, LSB-aligned in the low sym_size bits, upper bits 0.
- block_done  out  1  one-cycle pulse on the handshake of a block's final symbol.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; in_ready=1.
  - sym_valid, sym_is_dc, sym_run, sym_size, sym_amp and block_done are all 0.
  - DC predictor is cleared to 0.
- Accept rule:
  - A block is captured when enable=1 and in_ready=1; all 64 coefficients are registered that cycle.
  - enable while in_ready=0 is ignored; no capture and no state change.
- Latency: the DC symbol presents sym_valid=1 on the cycle after capture.
- Symbol handshake:
  - A symbol transfers on the cycle with sym_valid && sym_ready.
  - While sym_valid=1 and sym_ready=0, all sym_* outputs are held stable.
- FSM states: IDLE -> DC -> SCAN -> (ZRL | AC) -> ... -> EOB -> IDLE.
- DC state:
  - diff = Q[0][0] - pred, computed at DIFF_W.
  - Outputs: sym_is_dc=1, sym_run=0, sym_size=category(diff).
  - On transfer, pred <= Q[0][0]; scan index k <= 1; run <= 0.
- SCAN state:
  - Examines one coefficient per cycle at zigzag index k (1..63); sym_valid=0 during scan cycles.
  - Zero coefficient: run++, k++.
  - Nonzero coefficient with run>=16: go to ZRL.
  - Nonzero coefficient with run<16: go to AC.
- ZRL state:
  - Emits run=15, size=0, amp=0.
  - On transfer, run -= 16, then re-evaluate the same k.
- AC state:
  - Emits run, size=category(coef), amp=encode(coef).
  - On transfer: run <= 0 and k++. If k was 63, the block ends without EOB (block_done on this transfer).
- End of scan: if k passes 63 with run>0, go to EOB. Any pending ZRLs are discarded.
- EOB state: emits run=0, size=0, amp=0; block_done on its transfer.
- in_ready returns to 1 the cycle after block_done.
- Category: bit length of |v|; 0 for v=0.
- Amplitude encoding: v if v>0; otherwise the low size bits of (v-1).
- Reset mid-block: the block is abandoned, the predictor returns to 0, and no block_done is produced.

Optional Feature:
- Macro: CR_RLE_RESTART_EN.
- Defined: adds port restart_clr (in, 1). When restart_clr=1 is sampled in IDLE, or together with an accepted enable, pred is cleared to 0 before that block's DC difference is computed. This supports JPEG restart intervals.
- Undefined: no such port; pred is cleared only by reset.

Decomposition:
- Shared package jpeg_rle_pkg:
  - ZIGZAG_ROW/ZIGZAG_COL constant arrays [0:63].
  - FSM state enum.
  - Symbol struct {is_dc, run, size, amp}.
  - ZRL/EOB constants.
- One sub-module, rle_size_encoder: combinational; signed value in, category and amplitude out. Instantiated once and shared by the DC and AC paths.

Test Plan:
- Reset, then an all-zero block with sym_ready=1 -> DC(size 0, amp 0), then EOB(run 0, size 0); block_done pulses once; in_ready=1 on the next cycle.
- Block with Q[0][0]=50, then a block with Q[0][0]=45 -> first DC size 6, amp 50; second DC diff -5, size 3, amp 3'b010.
- Q[0][1]=3, Q[0][2]=-1, all others 0 -> DC(0,0), AC(run 0, size 2, amp 3), AC(run 3, size 1, amp 0), EOB.
- Only Q[7][7]=1 -> DC, ZRL x3, AC(run 14, size 1, amp 1), no EOB; block_done on the AC transfer.
- Checkerboard block with DC=-1024, then a block with DC=1023 -> DC size 11, amp 1023; next DC diff 2047, size 11, amp 2047. Hold sym_ready=0 for 5 cycles mid-block -> outputs stable and the symbol count unchanged.
- Assert rst mid-scan, then send a block with DC=7 -> no block_done for the aborted block; new DC diff 7, size 3, amp 7. A second enable while busy is ignored.

Source files
------------

// File: rtl/jpeg_rle_pkg.sv
// jpeg_rle_pkg: zigzag scan tables, FSM states and symbol type shared by the Cr RLE stage
package jpeg_rle_pkg;
    localparam int AMP_W = 11;
    typedef enum logic [2:0] {S_IDLE, S_DC, S_SCAN, S_ZRL, S_AC, S_EOB} state_t;
    typedef struct packed {
        logic             is_dc;
        logic [3:0]       run;
        logic [3:0]       size;
        logic [AMP_W-1:0] amp;
    } sym_t;
    localparam sym_t SYM_ZRL = '{is_dc: 1'b0, run: 4'd15, size: 4'd0, amp: '0};
    localparam sym_t SYM_EOB = '0;
    localparam int ZIGZAG_ROW [0:63] = '{
        0, 0, 1, 2, 1, 0, 0, 1,
        2, 3, 4, 3, 2, 1, 0, 0,
        1, 2, 3, 4, 5, 6, 5, 4,
        3, 2, 1, 0, 0, 1, 2, 3,
        4, 5, 6, 7, 7, 6, 5, 4,
        3, 2, 1, 2, 3, 4, 5, 6,
        7, 7, 6, 5, 4, 3, 4, 5,
        6, 7, 7, 6, 5, 6, 7, 7
    };
    localparam int ZIGZAG_COL [0:63] = '{
        0, 1, 0, 0, 1, 2, 3, 2,
        1, 0, 0, 1, 2, 3, 4, 5,
        4, 3, 2, 1, 0, 0, 1, 2,
        3, 4, 5, 6, 7, 6, 5, 4,
        3, 2, 1, 0, 1, 2, 3, 4,
        5, 6, 7, 7, 6, 5, 4, 3,
        2, 3, 4, 5, 6, 7, 7, 6,
        5, 4, 5, 6, 7, 7, 6, 7
    };
endpackage

// File: rtl/rle_size_encoder.sv
// rle_size_encoder: JPEG magnitude category and amplitude bits of a signed value
module rle_size_encoder #(
    parameter int W     = 12,
    parameter int AMP_W = 11
) (
    input  logic signed [W-1:0] value,
    output logic [3:0]          size,
    output logic [AMP_W-1:0]    amp
);
    logic [W-1:0] mag, mask;
    always_comb begin
        mag = value[W-1] ? -value : value;
        size = '0;
        for (int i = 0; i < W; i++) if (mag[i]) size = 4'(i + 1);
        mask = (W'(1) << size) - W'(1);
        amp = value[W-1] ? AMP_W'((value - W'(1)) & mask) : AMP_W'(value);
    end
endmodule

// File: rtl/cr_zigzag_rle.sv
// cr_zigzag_rle: zigzag scan + JPEG DC/AC run-length symbolizer; CR_RLE_RESTART_EN adds restart_clr
module cr_zigzag_rle
    import jpeg_rle_pkg::*;
#(
    parameter int COEF_W = 11,
    parameter int DIFF_W = 12
) (
    input  logic                              clk,
    input  logic                              rst,
`ifdef CR_RLE_RESTART_EN
    input  logic                              restart_clr,
`endif
    input  logic                              enable,
    input  logic signed [0:7][0:7][COEF_W-1:0] Q,
    output logic                              in_ready,
    output logic                              sym_valid,
    input  logic                              sym_ready,
    output logic                              sym_is_dc,
    output logic [3:0]                        sym_run,
    output logic [3:0]                        sym_size,
    output logic [10:0]                       sym_amp,
    output logic                              block_done
);
    state_t state, nstate;
    logic signed [0:7][0:7][COEF_W-1:0] q;
    logic [5:0] k, run;
    logic signed [COEF_W-1:0] pred, dc, coef;
    logic signed [DIFF_W-1:0] diff, enc_in;
    logic [3:0] enc_size;
    logic [AMP_W-1:0] enc_amp;
    logic fire, last, pred_clr;
    sym_t sym;

    assign dc = q[0][0];
    assign coef = q[3'(ZIGZAG_ROW[k])][3'(ZIGZAG_COL[k])];
    assign diff = DIFF_W'(dc) - DIFF_W'(pred);
    assign enc_in = state == S_DC ? diff : DIFF_W'(coef);

`ifdef CR_RLE_RESTART_EN
    assign pred_clr = state == S_IDLE && restart_clr;
`else
    assign pred_clr = 1'b0;
`endif

    rle_size_encoder #(.W(DIFF_W), .AMP_W(AMP_W)) u_enc (
        .value(enc_in),
        .size (enc_size),
        .amp  (enc_amp)
    );

    always_comb begin
        sym = state == S_DC  ? sym_t'{1'b1, 4'd0, enc_size, enc_amp}
            : state == S_AC  ? sym_t'{1'b0, run[3:0], enc_size, enc_amp}
            : state == S_ZRL ? SYM_ZRL : SYM_EOB;
        sym_valid = state inside {S_DC, S_ZRL, S_AC, S_EOB};
        fire = sym_valid && sym_ready;
        last = state == S_EOB || (state == S_AC && k == 6'd63);
    end

    assign in_ready   = state == S_IDLE;
    assign block_done = fire && last;
    assign sym_is_dc  = sym.is_dc;
    assign sym_run    = sym.run;
    assign sym_size   = sym.size;
    assign sym_amp    = sym.amp;

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  nstate = enable ? S_DC : S_IDLE;
            S_DC:    nstate = fire ? S_SCAN : S_DC;
            S_SCAN:  nstate = coef != '0 ? (run >= 6'd16 ? S_ZRL : S_AC) : k == 6'd63 ? S_EOB : S_SCAN;
            S_ZRL:   nstate = fire ? S_SCAN : S_ZRL;
            S_AC:    nstate = !fire ? S_AC : k == 6'd63 ? S_IDLE : S_SCAN;
            S_EOB:   nstate = fire ? S_IDLE : S_EOB;
            default: nstate = S_IDLE;
        endcase
    end

    // a ZRL returns to SCAN so the same coefficient is re-evaluated with the reduced run
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= S_IDLE;
            k     <= '0;
            run   <= '0;
            pred  <= '0;
        end else begin
            state <= nstate;
            if (pred_clr) pred <= '0;
            else if (state == S_DC && fire) pred <= dc;
            if (state == S_DC && fire) begin
                k   <= 6'd1;
                run <= '0;
            end else if (state == S_SCAN && coef == '0) begin
                k   <= k + 6'd1;
                run <= run + 6'd1;
            end else if (state == S_ZRL && fire) begin
                run <= run - 6'd16;
            end else if (state == S_AC && fire) begin
                k   <= k + 6'd1;
                run <= '0;
            end
        end

    always_ff @(posedge clk)
        if (in_ready && enable) q <= Q;
endmodule

// File: tb/tb_cr_zigzag_rle.sv
// tb_cr_zigzag_rle: table, directed and randomized checks of cr_zigzag_rle against a symbol-level model
module tb_cr_zigzag_rle;
    typedef struct packed {
        logic        dc;
        logic [3:0]  run;
        logic [3:0]  size;
        logic [10:0] amp;
    } esym_t;
    typedef struct {
        int dc;
        int size;
        int amp;
    } dc_vec_t;

    logic clk = 0, rst = 0, enable = 0, sym_ready = 1;
    logic signed [0:7][0:7][10:0] Q = '0;
    logic in_ready, sym_valid, sym_is_dc, block_done;
    logic [3:0] sym_run, sym_size;
    logic [10:0] sym_amp;
    int n_cmp = 0, n_bad = 0;
    int blk [0:7][0:7];
    int zr [0:63], zc [0:63];
    int mpred = 0;
    esym_t exp_q[$], rx_q[$];

    always #5 clk = ~clk;

    cr_zigzag_rle dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CR_RLE_RESTART_EN
        .restart_clr(1'b0),
`endif
        .enable    (enable),
        .Q         (Q),
        .in_ready  (in_ready),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_is_dc (sym_is_dc),
        .sym_run   (sym_run),
        .sym_size  (sym_size),
        .sym_amp   (sym_amp),
        .block_done(block_done)
    );

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int cat(int v);
        int a = v < 0 ? -v : v;
        int n = 0;
        while (a > 0) begin
            n++;
            a = a >> 1;
        end
        return n;
    endfunction

    function automatic esym_t sy(bit d, int run, int size, int amp);
        return {d, 4'(run), 4'(size), 11'(amp)};
    endfunction

    function automatic esym_t mk(bit d, int run, int v);
        int s = cat(v);
        int a = v > 0 ? v : (v - 1) & ((1 << s) - 1);
        return sy(d, run, s, a);
    endfunction

    function automatic esym_t cur();
        return {sym_is_dc, sym_run, sym_size, sym_amp};
    endfunction

    function automatic esym_t rx(int i);
        return i < rx_q.size() ? rx_q[i] : '1;
    endfunction

    task automatic clear_blk();
        foreach (blk[r, c]) blk[r][c] = 0;
    endtask

    task automatic model();
        int run = 0;
        int v;
        exp_q.delete();
        exp_q.push_back(mk(1, 0, blk[0][0] - mpred));
        mpred = blk[0][0];
        for (int i = 1; i < 64; i++) begin
            v = blk[zr[i]][zc[i]];
            if (v == 0) run++;
            else begin
                while (run > 15) begin
                    exp_q.push_back(mk(0, 15, 0));
                    run -= 16;
                end
                exp_q.push_back(mk(0, run, v));
                run = 0;
            end
        end
        if (run > 0) exp_q.push_back(mk(0, 0, 0));
    endtask

    task automatic run_block(input int stall_at, input bit rnd, input bit busy_en, input int abort_at);
        int got = 0;
        int cyc = 0;
        int stall = stall_at;
        esym_t s, hold;
        model();
        rx_q.delete();
        while (!in_ready && cyc < 100) begin
            step();
            cyc++;
        end
        chk(in_ready, "in_ready_wait", in_ready, 1);
        foreach (blk[r, c]) Q[r][c] = 11'(blk[r][c]);
        enable = 1;
        sym_ready = 1;
        step();
        enable = 0;
        chk(sym_valid && sym_is_dc, "dc_latency", {sym_valid, sym_is_dc}, 3);
        cyc = 0;
        while (got < exp_q.size() && cyc < 3000) begin
            sym_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
            #1;
            if (got == abort_at) begin
                rst = 0;
                #1;
                chk(!sym_valid && in_ready && !block_done, "abort_idle", {sym_valid, in_ready, block_done}, 2);
                repeat (2) begin
                    step();
                    chk(!block_done, "abort_done_reset", block_done, 0);
                end
                rst = 1;
                repeat (2) begin
                    step();
                    chk(!block_done && in_ready && !sym_valid, "abort_quiet", {block_done, in_ready, sym_valid}, 2);
                end
                mpred = 0;
                return;
            end
            if (sym_valid && got == stall) begin
                stall = -1;
                sym_ready = 0;
                hold = cur();
                repeat (5) begin
                    step();
                    chk(sym_valid && cur() == hold && !block_done, "stall_hold", int'(cur()), int'(hold));
                end
                sym_ready = 1;
                #1;
            end
            if (busy_en && got == 1) begin
                chk(!in_ready, "busy_in_ready", in_ready, 0);
                Q[0][0] = 11'd100;
                enable = 1;
            end
            if (sym_valid && sym_ready) begin
                s = cur();
                rx_q.push_back(s);
                chk(s == exp_q[got], "symbol", int'(s), int'(exp_q[got]));
                chk(block_done == (got == exp_q.size() - 1), "block_done", block_done, int'(got == exp_q.size() - 1));
                got++;
            end else begin
                chk(!block_done, "stray_done", block_done, 0);
            end
            step();
            enable = 0;
            cyc++;
        end
        chk(got == exp_q.size(), "symbol_count", got, exp_q.size());
        chk(in_ready, "in_ready_after", in_ready, 1);
    endtask

    initial begin
        dc_vec_t tbl [8];
        int n, lo, hi, d, r0;
        n = 0;
        for (int s = 0; s < 15; s++) begin
            lo = s > 7 ? s - 7 : 0;
            hi = s < 7 ? s : 7;
            for (int i = 0; i <= hi - lo; i++) begin
                zr[n] = (s % 2) ? lo + i : hi - i;
                zc[n] = s - zr[n];
                n++;
            end
        end
        tbl = '{'{0, 0, 0}, '{50, 6, 50}, '{45, 3, 2}, '{-1024, 11, 978},
                '{1023, 11, 2047}, '{1022, 1, 0}, '{-1, 10, 0}, '{0, 1, 1}};

        #7;
        chk(in_ready, "rst_in_ready", in_ready, 1);
        chk(!sym_valid, "rst_sym_valid", sym_valid, 0);
        chk(!sym_is_dc, "rst_sym_is_dc", sym_is_dc, 0);
        chk(sym_run == 0, "rst_sym_run", sym_run, 0);
        chk(sym_size == 0, "rst_sym_size", sym_size, 0);
        chk(sym_amp == 0, "rst_sym_amp", sym_amp, 0);
        chk(!block_done, "rst_block_done", block_done, 0);
        repeat (2) step();
        rst = 1;
        step();

        foreach (tbl[i]) begin
            clear_blk();
            blk[0][0] = tbl[i].dc;
            run_block(-1, 0, 0, -1);
            chk(rx(0) == sy(1, 0, tbl[i].size, tbl[i].amp), "tbl_dc", int'(rx(0)), int'(sy(1, 0, tbl[i].size, tbl[i].amp)));
            chk(rx(1) == sy(0, 0, 0, 0), "tbl_eob", int'(rx(1)), 0);
        end

        clear_blk();
        blk[0][1] = 3;
        blk[0][2] = -1;
        run_block(-1, 0, 0, -1);
        chk(rx(0) == sy(1, 0, 0, 0), "ac_dc", int'(rx(0)), int'(sy(1, 0, 0, 0)));
        chk(rx(1) == sy(0, 0, 2, 3), "ac_first", int'(rx(1)), int'(sy(0, 0, 2, 3)));
        chk(rx(2) == sy(0, 3, 1, 0), "ac_second", int'(rx(2)), int'(sy(0, 3, 1, 0)));
        chk(rx(3) == sy(0, 0, 0, 0), "ac_eob", int'(rx(3)), 0);
        chk(rx_q.size() == 4, "ac_count", rx_q.size(), 4);

        clear_blk();
        blk[7][7] = 1;
        run_block(-1, 0, 0, -1);
        for (int i = 1; i < 4; i++)
            chk(rx(i) == sy(0, 15, 0, 0), "zrl", int'(rx(i)), int'(sy(0, 15, 0, 0)));
        chk(rx(4) == sy(0, 14, 1, 1), "zrl_last_ac", int'(rx(4)), int'(sy(0, 14, 1, 1)));
        chk(rx_q.size() == 5, "zrl_count", rx_q.size(), 5);

        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[r][c] = ((r + c) % 2) ? ((r % 2) ? 5 : -3) : 0;
        blk[0][0] = -1024;
        run_block(6, 0, 0, -1);
        chk(rx(0) == sy(1, 0, 11, 1023), "chk_dc_min", int'(rx(0)), int'(sy(1, 0, 11, 1023)));
        clear_blk();
        blk[0][0] = 1023;
        run_block(1, 0, 0, -1);
        chk(rx(0) == sy(1, 0, 11, 2047), "chk_dc_max", int'(rx(0)), int'(sy(1, 0, 11, 2047)));

        clear_blk();
        blk[0][0] = 300;
        blk[0][1] = 5;
        blk[3][3] = -2;
        blk[7][7] = 9;
        run_block(-1, 0, 0, 2);
        clear_blk();
        blk[0][0] = 7;
        run_block(-1, 0, 1, -1);
        chk(rx(0) == sy(1, 0, 3, 7), "post_reset_dc", int'(rx(0)), int'(sy(1, 0, 3, 7)));
        clear_blk();
        blk[0][0] = 10;
        run_block(-1, 0, 0, -1);
        chk(rx(0) == sy(1, 0, 2, 3), "busy_ignored_dc", int'(rx(0)), int'(sy(1, 0, 2, 3)));

        for (int b = 0; b < 30; b++) begin
            d = $urandom_range(2);
            foreach (blk[r, c]) begin
                r0 = $urandom_range(99);
                if (r0 >= (d == 0 ? 97 : d == 1 ? 80 : 40))
                    blk[r][c] = ($urandom_range(3) == 0) ? int'($urandom_range(2047)) - 1024
                                                        : int'($urandom_range(14)) - 7;
                else
                    blk[r][c] = 0;
            end
            blk[0][0] = int'($urandom_range(2047)) - 1024;
            run_block(($urandom_range(3) == 0) ? int'($urandom_range(3)) : -1, 1, 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
